// File: rtl/min_dist_select.sv
// Streams up to centroid_num distances for one point and reports the closest
// centroid (lowest index wins ties), holding the result until acknowledged.
module min_dist_select #(
  parameter int centroid_num = 8,
  parameter int dist_width   = 16,
  parameter int idx_width    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [idx_width:0]    k_num,
  input  logic                  dist_valid,
  input  logic [dist_width-1:0] dist_in,
  output logic                  dist_ready,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [idx_width-1:0]  min_index,
  output logic [dist_width-1:0] min_dist,
  output logic                  busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [idx_width:0] K_MAX = (idx_width + 1)'(centroid_num);

  logic [1:0]         state;
  logic [idx_width:0] cnt;
  logic [idx_width:0] k_act;
  logic [idx_width:0] k_sel;

  // Out-of-range or zero requests fall back to the full centroid set.
  assign k_sel = ((k_num == '0) || (k_num > K_MAX)) ? K_MAX : k_num;

  assign dist_ready   = (state == COLLECT);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      k_act     <= K_MAX;
      min_index <= '0;
      min_dist  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            cnt   <= '0;
            k_act <= k_sel;
          end
        end
        COLLECT: begin
          if (dist_valid) begin
            // Strict compare keeps the earlier (lower) index on ties.
            if ((cnt == '0) || (dist_in < min_dist)) begin
              min_dist  <= dist_in;
              min_index <= cnt[idx_width-1:0];
            end
            cnt <= cnt + 1'b1;
            if (cnt == k_act - 1'b1) state <= DONE;
          end
        end
        DONE: begin
          if (result_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/min_dist_select.md
MIN_DIST_SELECT -- requirements
Module: min_dist_select

Interface
REQ-001 Parameter: centroid_num, default 8, maximum number of centroid distances compared per point.
REQ-002 Parameter: dist_width, default 16, width of one Manhattan distance (7 x 13-bit coordinate differences).
REQ-003 Parameter: idx_width, default 3, width of the centroid index (idx_width = clog2(centroid_num)).
REQ-004 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: start, input, 1, one-cycle pulse that begins a new point's comparison.
REQ-007 Port: k_num, input, idx_width+1, number of active centroids, sampled on an accepted start.
REQ-008 Port: dist_valid, input, 1, dist_in holds a valid distance.
REQ-009 Port: dist_in, input, dist_width, distance of the current point to the next centroid, in ascending centroid order.
REQ-010 Port: dist_ready, output, 1, block accepts a distance this cycle.
REQ-011 Port: result_valid, output, 1, min_index and min_dist are valid.
REQ-012 Port: result_ack, input, 1, consumer takes the result.
REQ-013 Port: min_index, output, idx_width, index of the closest centroid.
REQ-014 Port: min_dist, output, dist_width, distance to the closest centroid.
REQ-015 Port: busy, output, 1, high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT and DONE.
REQ-017 IDLE: start=1 SHALL move to COLLECT next cycle, clear the centroid counter to 0 and latch the effective k.
REQ-018 Effective k SHALL be k_num, except that k_num=0 or k_num>centroid_num SHALL be replaced by centroid_num.
REQ-019 dist_ready SHALL be 1 only in COLLECT; a distance is accepted only on a cycle where dist_valid=1 and dist_ready=1.
REQ-020 On the first accepted distance (counter=0), min_dist SHALL load dist_in and min_index SHALL load 0.
REQ-021 On a later accept, min_dist and min_index SHALL update to dist_in and the counter only if dist_in < min_dist (strict unsigned); on a tie the lower index SHALL be kept.
REQ-022 The counter SHALL increment by 1 per accept, and the FSM SHALL move to DONE on the accept where counter = k-1.
REQ-023 DONE: result_valid SHALL be 1, and min_index and min_dist SHALL be held stable until result_ack=1.
REQ-024 DONE with result_ack=1 SHALL return to IDLE next cycle with result_valid=0; min_index and min_dist SHALL keep their values.
REQ-025 start SHALL be ignored in COLLECT and DONE.
REQ-026 dist_valid SHALL be ignored outside COLLECT.
REQ-027 Latency: result_valid SHALL rise on the cycle after the k-th accept; with back-to-back valid input, this is k+1 cycles after start.
REQ-028 Cycles with dist_valid=0 in COLLECT SHALL stall without changing state.
REQ-029 A start and result_ack in the same cycle while in DONE SHALL only acknowledge; the start is not accepted.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter=0, k=centroid_num, min_index=0, min_dist=0, result_valid=0, dist_ready=0 and busy=0.
REQ-031 Reset asserted mid-COLLECT or in DONE SHALL discard the partial result; no result_valid SHALL follow after reset is released.

Verification
REQ-032 Scenario: start with k_num=8 and distances 50,40,60,40,10,90,10,70 back-to-back -> result_valid at cycle 9 after start, min_index=4, min_dist=10.
REQ-033 Scenario: k_num=3 and distances 5,5,5 -> min_index=0, min_dist=5 (tie keeps lowest index).
REQ-034 Scenario: k_num=0 -> eight accepts required; after seven accepts, result_valid remains 0.
REQ-035 Scenario: dist_valid gaps of 2 cycles between samples and result_ack held low for 5 cycles -> result unchanged and stable, dist_ready=0 in DONE, start pulses ignored.
REQ-036 Scenario: rst_n low after 4 accepts, then released and a new start with k_num=2 and distances 0xFFFF,0x0001 -> min_index=1, min_dist=1, with no result from the aborted point.
REQ-037 Scenario: result_ack together with start in DONE -> IDLE next cycle, busy=0; a subsequent start is accepted.
